// File: rtl/nn_pkg.sv
// Shared state encoding, fixed-point formats and arithmetic helpers for the
// N-neuron layer MAC engine.
package nn_pkg;

  localparam int QM = 3;
  localparam int QN = 5;
  localparam int WM = 3;
  localparam int WN = 5;
  localparam int DW = QM + QN;
  localparam int WW = WM + WN;
  localparam int PW = DW + WW;
  // Width of the pre-saturation value handed to saturate(); must exceed AW+1.
  localparam int SW = 32;

  typedef enum logic [2:0] {IDLE, READ, MAC, POST, WRITE, DONE} state_t;

  typedef struct packed {
    logic [DW-1:0] val;
    logic          clip;
  } sat_t;

  // Accumulator width: N full-precision products plus a sign guard bit.
  function automatic int acc_width(input int n);
    return PW + $clog2(n) + 1;
  endfunction

  function automatic sat_t saturate(input logic signed [SW-1:0] v);
    sat_t                  r;
    logic signed [SW-1:0]  hi;
    logic signed [SW-1:0]  lo;
    hi = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    lo = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    if (v > hi) begin
      r.val  = hi[DW-1:0];
      r.clip = 1'b1;
    end else if (v < lo) begin
      r.val  = lo[DW-1:0];
      r.clip = 1'b1;
    end else begin
      r.val  = v[DW-1:0];
      r.clip = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
    return v[DW-1] ? {DW{1'b0}} : v;
  endfunction

endpackage

// File: rtl/n_neuron_layer_mac_lane.sv
// One neuron's datapath: signed MAC accumulator plus bias add, floor rescale,
// saturation and optional ReLU.
module neuron_mac_lane
  import nn_pkg::*;
#(
  parameter int N = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] x,
  input  logic [WW-1:0] w,
  input  logic [DW-1:0] bias,
  input  logic          last_layer,
  output logic [DW-1:0] y,
  output logic          sat
);

  localparam int AW = acc_width(N);

  logic signed [AW-1:0] acc_r;
  logic signed [PW-1:0] prod_s;
  logic signed [AW:0]   sum_s;
  logic signed [AW:0]   shr_s;
  sat_t                 sat_s;

  assign prod_s = $signed(x) * $signed(w);

  // Accumulator: cleared on each layer read, one product added per MAC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= {AW{1'b0}};
    end else if (clr) begin
      acc_r <= {AW{1'b0}};
    end else if (en) begin
      acc_r <= acc_r + {{(AW-PW){prod_s[PW-1]}}, prod_s};
    end else begin
      acc_r <= acc_r;
    end
  end

  // Bias joins at product scale, then an arithmetic shift floors back to data scale.
  always_comb begin
    sum_s = {acc_r[AW-1], acc_r} + ({{(AW+1-DW){bias[DW-1]}}, bias} <<< WN);
    shr_s = sum_s >>> WN;
    sat_s = saturate({{(SW-AW-1){shr_s[AW]}}, shr_s});
    if (last_layer) begin
      y = sat_s.val;
    end else begin
      y = relu(sat_s.val);
    end
    sat = sat_s.clip;
  end

endmodule

// File: rtl/n_neuron_layer_mac.sv
// Layer sequencer for the N-neuron network: reads each layer's operands, runs
// N parallel MAC lanes, and writes back activated, saturated results.
module n_neuron_layer_mac
  import nn_pkg::*;
#(
  parameter  int M   = 3,
  parameter  int N   = 2,
  localparam int LAW = (M > 2) ? $clog2(M-1) : 1,
  localparam int KW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic                        read_en,
  output logic [LAW-1:0]              layer_addr,
  input  logic [N-1:0][DW-1:0]        inputs,
  input  logic [N-1:0][N-1:0][WW-1:0] weights,
  input  logic [N-1:0][DW-1:0]        bias,
  output logic [N-1:0][DW-1:0]        result,
  output logic                        write_en
);

  state_t                      state_r;
  logic [KW-1:0]               k_r;
  logic [LAW-1:0]              layer_r;
  logic [N-1:0][DW-1:0]        inputs_r;
  logic [N-1:0][N-1:0][WW-1:0] weights_r;
  logic [N-1:0][DW-1:0]        bias_r;
  logic [N-1:0][DW-1:0]        result_r;
  logic                        busy_r;
  logic                        done_r;
  logic                        overflow_r;
  logic                        read_en_r;
  logic                        write_en_r;
  logic                        last_layer_s;
  logic                        clr_s;
  logic                        en_s;
  logic [N-1:0][DW-1:0]        y_s;
  logic [N-1:0]                sat_s;

  assign last_layer_s = (layer_r == LAW'(M-2));
  assign clr_s        = (state_r == READ);
  assign en_s         = (state_r == MAC);

  for (genvar j = 0; j < N; j++) begin : g_lane
    neuron_mac_lane #(.N(N)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr_s),
      .en         (en_s),
      .x          (inputs_r[k_r]),
      .w          (weights_r[j][k_r]),
      .bias       (bias_r[j]),
      .last_layer (last_layer_s),
      .y          (y_s[j]),
      .sat        (sat_s[j])
    );
  end

  // Sequencer: pulses are cleared every cycle and raised only on the entering transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      k_r        <= {KW{1'b0}};
      layer_r    <= {LAW{1'b0}};
      inputs_r   <= {(N*DW){1'b0}};
      weights_r  <= {(N*N*WW){1'b0}};
      bias_r     <= {(N*DW){1'b0}};
      result_r   <= {(N*DW){1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
      read_en_r  <= 1'b0;
      write_en_r <= 1'b0;
    end else begin
      read_en_r  <= 1'b0;
      write_en_r <= 1'b0;
      done_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= READ;
            read_en_r  <= 1'b1;
            busy_r     <= 1'b1;
            overflow_r <= 1'b0;
            layer_r    <= {LAW{1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          inputs_r  <= inputs;
          weights_r <= weights;
          bias_r    <= bias;
          k_r       <= {KW{1'b0}};
          state_r   <= MAC;
        end
        MAC: begin
          if (k_r == KW'(N-1)) begin
            k_r     <= {KW{1'b0}};
            state_r <= POST;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        POST: begin
          result_r   <= y_s;
          overflow_r <= overflow_r | (|sat_s);
          write_en_r <= 1'b1;
          state_r    <= WRITE;
        end
        WRITE: begin
          if (last_layer_s) begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            layer_r   <= layer_r + LAW'(1);
            read_en_r <= 1'b1;
            state_r   <= READ;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign overflow   = overflow_r;
  assign read_en    = read_en_r;
  assign write_en   = write_en_r;
  assign layer_addr = layer_r;
  assign result     = result_r;

endmodule

// File: tb/tb_n_neuron_layer_mac.sv
// Self-checking bench for n_neuron_layer_mac (M=3, N=2, Q3.5 data, Q3.5 weights):
// acts as the layer memory and scoreboards each written layer against a model.
module tb_n_neuron_layer_mac;

  localparam int M  = 3;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int WW = 8;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        start;
  logic                        busy;
  logic                        done;
  logic                        overflow;
  logic                        read_en;
  logic [0:0]                  layer_addr;
  logic [N-1:0][DW-1:0]        inputs;
  logic [N-1:0][N-1:0][WW-1:0] weights;
  logic [N-1:0][DW-1:0]        bias;
  logic [N-1:0][DW-1:0]        result;
  logic                        write_en;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-layer operand tables: lx[layer][k], lw[layer][j][k], lb[layer][j].
  int lx[2][2];
  int lw[2][2][2];
  int lb[2][2];

  logic [N-1:0][DW-1:0] exp_q[$];
  bit                   exp_ovf;

  always #5 clk = ~clk;

  n_neuron_layer_mac #(.M(M), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .read_en    (read_en),
    .layer_addr (layer_addr),
    .inputs     (inputs),
    .weights    (weights),
    .bias       (bias),
    .result     (result),
    .write_en   (write_en)
  );

  function automatic logic [N-1:0][DW-1:0] model_layer(input int l, output bit clip);
    logic [N-1:0][DW-1:0] r;
    int acc;
    int y;
    clip = 1'b0;
    for (int j = 0; j < N; j++) begin
      acc = lb[l][j] * 32;
      for (int k = 0; k < N; k++) acc += lx[l][k] * lw[l][j][k];
      y = acc >>> 5;
      if (y > 127) begin
        y = 127;
        clip = 1'b1;
      end else if (y < -128) begin
        y = -128;
        clip = 1'b1;
      end
      if (l < M - 2 && y < 0) y = 0;
      r[j] = 8'(y);
    end
    return r;
  endfunction

  task automatic drive_layer(input int l);
    bit c;
    for (int j = 0; j < N; j++) begin
      inputs[j] = 8'(lx[l][j]);
      bias[j]   = 8'(lb[l][j]);
      for (int k = 0; k < N; k++) weights[j][k] = 8'(lw[l][j][k]);
    end
    exp_q.push_back(model_layer(l, c));
    if (c) exp_ovf = 1'b1;
  endtask

  task automatic run_pass(input bit hold_start, input bit mid_pulse, input bit abort_l1);
    int   rd_n, wr_n, dn_n, dn_cyc, extra;
    int   rd_cyc[2];
    int   wr_cyc[2];
    bit   busy_ok, scramble;
    logic [N-1:0][DW-1:0] exp_r, last_r;
    logic [21:0] obs;
    rd_n = 0; wr_n = 0; dn_n = 0; dn_cyc = -100; extra = 0;
    rd_cyc = '{-100, -100};
    wr_cyc = '{-100, -100};
    busy_ok = 1'b1; scramble = 1'b0; last_r = '0;
    exp_q.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    drive_layer(0);
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      if (scramble) begin
        scramble = 1'b0;
        inputs  = 16'($urandom);
        weights = 32'($urandom);
        bias    = 16'($urandom);
      end
      if (mid_pulse && c == rd_cyc[0] + 1) start = 1'b1;
      if (abort_l1 && rd_n == 2 && c == rd_cyc[1] + 1) begin
        rst = 1'b1;
        #1;
        obs = {busy, done, overflow, read_en, write_en, layer_addr, result};
        n_checks++;
        if (obs !== 22'd0) begin
          n_fail++;
          $display("FAIL abort_outputs: got %h expected 000000", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (write_en === 1'b1 || done === 1'b1 || read_en === 1'b1 || busy === 1'b1) extra++;
        end
        n_checks++;
        if (extra != 0) begin
          n_fail++;
          $display("FAIL abort_quiet: got %0d active cycles expected 0", extra);
        end
        exp_q.delete();
        return;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (c == 1) begin
        n_checks++;
        if (overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL overflow_clear: got %b expected 0", overflow);
        end
      end
      if (read_en === 1'b1) begin
        n_checks++;
        if (layer_addr !== 1'(rd_n)) begin
          n_fail++;
          $display("FAIL layer_addr_%0d: got %0d expected %0d", rd_n, layer_addr, rd_n);
        end
        if (rd_n < 2) rd_cyc[rd_n] = c;
        rd_n++;
        scramble = 1'b1;
      end
      if (write_en === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL result_%0d: got %h with nothing expected", wr_n, result);
        end else begin
          exp_r  = exp_q.pop_front();
          last_r = exp_r;
          if (result !== exp_r) begin
            n_fail++;
            $display("FAIL result_%0d: got %h expected %h", wr_n, result, exp_r);
          end
        end
        if (wr_n < 2) wr_cyc[wr_n] = c;
        wr_n++;
        if (wr_n == 1) drive_layer(1);
      end
      if (done === 1'b1) begin
        dn_cyc = c;
        dn_n++;
        start = 1'b0;
        break;
      end
    end
    n_checks++;
    if (dn_n != 1) begin
      n_fail++;
      $display("FAIL done_seen: got %0d pulses expected 1 within budget", dn_n);
    end
    n_checks++;
    if (rd_n != 2 || wr_n != 2) begin
      n_fail++;
      $display("FAIL pulse_count: got read %0d write %0d expected 2 and 2", rd_n, wr_n);
    end
    n_checks++;
    if (rd_cyc[0] != 1 || rd_cyc[1] - rd_cyc[0] != 5) begin
      n_fail++;
      $display("FAIL read_timing: got cycles %0d,%0d expected 1,6", rd_cyc[0], rd_cyc[1]);
    end
    n_checks++;
    if (wr_cyc[0] - rd_cyc[0] != 4 || wr_cyc[1] - rd_cyc[1] != 4) begin
      n_fail++;
      $display("FAIL write_timing: got cycles %0d,%0d expected %0d,%0d",
               wr_cyc[0], wr_cyc[1], rd_cyc[0] + 4, rd_cyc[1] + 4);
    end
    n_checks++;
    if (dn_cyc - wr_cyc[1] != 1 || dn_cyc - rd_cyc[0] != 10) begin
      n_fail++;
      $display("FAIL done_timing: got cycle %0d expected %0d", dn_cyc, rd_cyc[0] + 10);
    end
    n_checks++;
    if (!busy_ok) begin
      n_fail++;
      $display("FAIL busy_span: got a low busy expected high from read to done");
    end
    n_checks++;
    if (overflow !== exp_ovf) begin
      n_fail++;
      $display("FAIL overflow: got %b expected %b", overflow, exp_ovf);
    end
    n_checks++;
    if (result !== last_r) begin
      n_fail++;
      $display("FAIL result_hold: got %h expected %h", result, last_r);
    end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (read_en === 1'b1 || write_en === 1'b1 || done === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL idle_after: got %0d active cycles expected 0", extra);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    inputs = '0; weights = '0; bias = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_done: got %b%b expected 00", busy, done);
    end
    n_checks++;
    if (read_en !== 1'b0 || write_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b%b expected 00", read_en, write_en);
    end
    n_checks++;
    if (overflow !== 1'b0 || layer_addr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf_addr: got %b%b expected 00", overflow, layer_addr);
    end
    n_checks++;
    if (result !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_result: got %h expected 0000", result);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_sat_table();
    lx = '{'{32, 32}, '{64, 64}};
    lw = '{'{'{32, 32}, '{32, 32}}, '{'{32, 32}, '{32, 32}}};
    lb = '{'{0, 0}, '{0, 0}};
  endtask

  task automatic load_relu_table();
    lx = '{'{32, -64}, '{0, 32}};
    lw = '{'{'{32, 32}, '{32, 0}}, '{'{0, -32}, '{32, 32}}};
    lb = '{'{0, 0}, '{0, 0}};
  endtask

  task automatic test_timing_saturation();
    load_sat_table();
    run_pass(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_relu();
    load_relu_table();
    run_pass(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_bias_round();
    lx = '{'{1, 0}, '{-1, 0}};
    lw = '{'{'{16, 0}, '{16, 0}}, '{'{16, 0}, '{0, 0}}};
    lb = '{'{32, 32}, '{0, 0}};
    run_pass(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_held();
    load_sat_table();
    run_pass(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_start_mid_mac();
    load_relu_table();
    run_pass(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_abort();
    load_relu_table();
    run_pass(1'b0, 1'b0, 1'b1);
    load_sat_table();
    run_pass(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_timing_saturation();
    test_relu();
    test_bias_round();
    test_start_held();
    test_start_mid_mac();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
